// File: rtl/debounce_event_pkg.sv
// Shared constants and helpers for the debounce_event block.
package debounce_event_pkg;

  // Legal parameter ranges for the debouncer.
  localparam int N_MIN          = 2;
  localparam int N_MAX          = 16;
  localparam int RATE_MIN       = 1;
  localparam int RATE_MAX       = 1 << 24;
  localparam int HOLD_TICKS_MIN = 1;
  localparam int REPEAT_MIN     = 1;

  // Bits needed to hold the values 0..value-1 (ceil log2), never less than 1.
  function automatic int cnt_width(input int unsigned value);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/debounce_event_channel.sv
// One debounce channel: input synchronizer, tick-driven sample shift register,
// debounced level with edge pulses, hold counter for long-press and, when
// DEBOUNCE_EVENT_REPEAT_EN is defined, an auto-repeat counter.
module debounce_event_channel
  import debounce_event_pkg::*;
#(
  parameter int N            = 3,
  parameter int HOLD_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall,
  output logic long_press,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int HOLD_W = cnt_width(HOLD_TICKS + 1);

  logic              sync_p0;
  logic              sync_p1;
  logic [N-1:0]      samp;
  logic [HOLD_W-1:0] hold_cnt;
  logic              out_d;
  logic              hold_full;

  // Two-flop synchronizer for the raw asynchronous level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= in;
      sync_p1 <= sync_p0;
    end
  end

  // Shift the synchronized level into the sample history on each tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) samp <= '0;
    else if (tick) samp <= {samp[N-2:0], sync_p1};
  end

  // Next debounced level: follow a unanimous history, otherwise hold.
  always_comb begin
    out_d = out;
    if (&samp)       out_d = 1'b1;
    else if (~|samp) out_d = 1'b0;
  end

  assign hold_full = (hold_cnt == HOLD_W'(HOLD_TICKS));

  // Debounced level plus edge pulses, aligned with the level change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      out  <= out_d;
      rise <= out_d & ~out;
      fall <= ~out_d & out;
    end
  end

  // Count ticks spent high, saturating once the long-press threshold is met.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_cnt <= '0;
    else if (!out) hold_cnt <= '0;
    else if (tick && !hold_full) hold_cnt <= hold_cnt + HOLD_W'(1);
  end

  // Long-press level and its one-shot; gated by out_d so release drops it with out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_press <= 1'b0;
      long_pulse <= 1'b0;
    end else begin
      long_press <= out_d & hold_full;
      long_pulse <= out_d & hold_full & ~long_press;
    end
  end

`ifdef DEBOUNCE_EVENT_REPEAT_EN
  localparam int RPT_W = cnt_width(REPEAT_TICKS);

  logic [RPT_W-1:0] rpt_cnt;

  // Auto-repeat: one pulse every REPEAT_TICKS ticks while long-press is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt      <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= 1'b0;
      if (!out_d) begin
        rpt_cnt <= '0;
      end else if (long_press && tick) begin
        if (rpt_cnt == RPT_W'(REPEAT_TICKS - 1)) begin
          rpt_cnt      <= '0;
          repeat_pulse <= 1'b1;
        end else begin
          rpt_cnt <= rpt_cnt + RPT_W'(1);
        end
      end
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/debounce_event.sv
// Multi-channel switch debouncer with edge, long-press and auto-repeat events.
// A shared prescaler produces the sample tick; each channel is an instance of
// debounce_event_channel. Define DEBOUNCE_EVENT_REPEAT_EN to build repeat logic.
module debounce_event
  import debounce_event_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int N            = 3,
  parameter int RATE         = 125000,
  parameter int HOLD_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] long_press,
  output logic [WIDTH-1:0] long_pulse,
  output logic [WIDTH-1:0] repeat_pulse,
  output logic             tick
);

  localparam int PRE_W = cnt_width(RATE);

  logic [PRE_W-1:0] pre_cnt;

  // Prescaler: count 0..RATE-1 and strobe tick as it wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else if (pre_cnt == PRE_W'(RATE - 1)) begin
      pre_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
      tick    <= 1'b0;
    end
  end

  for (genvar k = 0; k < WIDTH; k++) begin : g_chan
    debounce_event_channel #(
      .N            (N),
      .HOLD_TICKS   (HOLD_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .tick         (tick),
      .in           (in[k]),
      .out          (out[k]),
      .rise         (rise[k]),
      .fall         (fall[k]),
      .long_press   (long_press[k]),
      .long_pulse   (long_pulse[k]),
      .repeat_pulse (repeat_pulse[k])
    );
  end

endmodule

// File: tb/tb_debounce_event.sv
// Directed bench for debounce_event (WIDTH=2, N=3, RATE=4, HOLD=5, REPEAT=2).
module tb_debounce_event;

  localparam int WIDTH        = 2;
  localparam int N            = 3;
  localparam int RATE         = 4;
  localparam int HOLD_TICKS   = 5;
  localparam int REPEAT_TICKS = 2;

`ifdef DEBOUNCE_EVENT_REPEAT_EN
  localparam bit RPT_EN = 1'b1;
`else
  localparam bit RPT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out, rise, fall, long_press, long_pulse, repeat_pulse;
  logic             tick;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  debounce_event #(
    .WIDTH(WIDTH), .N(N), .RATE(RATE),
    .HOLD_TICKS(HOLD_TICKS), .REPEAT_TICKS(REPEAT_TICKS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .out(out), .rise(rise), .fall(fall),
    .long_press(long_press), .long_pulse(long_pulse),
    .repeat_pulse(repeat_pulse), .tick(tick)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_tick();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2 * RATE + 2; i++) begin
      step();
      if (tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL tick_timeout: tick=%b, required a tick within %0d cycles", tick, 2 * RATE + 2);
    end
  endtask

  task automatic test_reset();
    logic [6*WIDTH:0] all_out;
    rst_n = 1'b1;
    in    = '0;
    #2 rst_n = 1'b0;
    step();
    step();
    all_out = {out, rise, fall, long_press, long_pulse, repeat_pulse, tick};
    tests++;
    if (all_out !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %b, required all zero", all_out);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      tests++;
      if (tick !== (i == 4)) begin
        fails++;
        $display("FAIL first_tick cycle %0d: tick=%b, required %b", i, tick, (i == 4));
      end
    end
  endtask

  task automatic test_bounce();
    wait_tick();
    in[1] = 1'b1;
    wait_tick();
    wait_tick();
    in[1] = 1'b0;
    for (int i = 0; i < 24; i++) begin
      step();
      tests++;
      if ({out[1], rise[1], fall[1]} !== 3'b000) begin
        fails++;
        $display("FAIL bounce cycle %0d: out/rise/fall[1]=%b, required 000", i, {out[1], rise[1], fall[1]});
      end
    end
  endtask

  task automatic test_press();
    wait_tick();
    in[0] = 1'b1;
    wait_tick();
    wait_tick();
    wait_tick();
    tests++;
    if (out[0] !== 1'b0) begin
      fails++;
      $display("FAIL press_third_tick: out[0]=%b, required 0", out[0]);
    end
    step();
    tests++;
    if (out[0] !== 1'b0) begin
      fails++;
      $display("FAIL press_samples_full: out[0]=%b, required 0", out[0]);
    end
    step();
    tests++;
    if ({out[0], rise[0], fall[0]} !== 3'b110) begin
      fails++;
      $display("FAIL press_rise: out/rise/fall[0]=%b, required 110", {out[0], rise[0], fall[0]});
    end
    step();
    tests++;
    if ({out[0], rise[0]} !== 2'b10) begin
      fails++;
      $display("FAIL press_rise_width: out/rise[0]=%b, required 10", {out[0], rise[0]});
    end
  endtask

  task automatic test_long_hold();
    bit   found;
    logic prev_lp;
    for (int i = 0; i < HOLD_TICKS; i++) wait_tick();
    tests++;
    if (long_press[0] !== 1'b0) begin
      fails++;
      $display("FAIL long_early: long_press[0]=%b, required 0", long_press[0]);
    end
    step();
    tests++;
    if ({long_press[0], long_pulse[0]} !== 2'b00) begin
      fails++;
      $display("FAIL long_count_full: long_press/pulse[0]=%b, required 00", {long_press[0], long_pulse[0]});
    end
    step();
    tests++;
    if ({long_press[0], long_pulse[0]} !== 2'b11) begin
      fails++;
      $display("FAIL long_assert: long_press/pulse[0]=%b, required 11", {long_press[0], long_pulse[0]});
    end
    for (int i = 1; i <= 24; i++) begin
      step();
      tests++;
      if ({long_press[0], long_pulse[0], repeat_pulse[0]} !==
          {1'b1, 1'b0, RPT_EN && (i % 8 == 7)}) begin
        fails++;
        $display("FAIL long_repeat cycle %0d: press/pulse/repeat[0]=%b, required %b", i,
                 {long_press[0], long_pulse[0], repeat_pulse[0]},
                 {1'b1, 1'b0, RPT_EN && (i % 8 == 7)});
      end
    end
    in[0]   = 1'b0;
    found   = 1'b0;
    prev_lp = long_press[0];
    for (int i = 0; i < 40; i++) begin
      step();
      if (out[0] === 1'b0) begin
        found = 1'b1;
        break;
      end
      prev_lp = long_press[0];
    end
    tests++;
    if (!found || prev_lp !== 1'b1 || {fall[0], long_press[0], rise[0]} !== 3'b100) begin
      fails++;
      $display("FAIL release: found=%b prev_lp=%b fall/lp/rise[0]=%b, required 1 1 100",
               found, prev_lp, {fall[0], long_press[0], rise[0]});
    end
    step();
    tests++;
    if ({fall[0], repeat_pulse[0], long_pulse[0]} !== 3'b000) begin
      fails++;
      $display("FAIL release_after: fall/repeat/pulse[0]=%b, required 000",
               {fall[0], repeat_pulse[0], long_pulse[0]});
    end
  endtask

  task automatic test_simultaneous();
    bit found;
    found = 1'b0;
    in    = 2'b11;
    for (int i = 0; i < 60; i++) begin
      step();
      if (rise !== 2'b00) begin
        found = 1'b1;
        break;
      end
    end
    tests++;
    if (!found || rise !== 2'b11 || out !== 2'b11) begin
      fails++;
      $display("FAIL simul_rise: found=%b rise=%b out=%b, required 1 11 11", found, rise, out);
    end
    step();
    tests++;
    if (rise !== 2'b00) begin
      fails++;
      $display("FAIL simul_rise_width: rise=%b, required 00", rise);
    end
  endtask

  task automatic test_reset_mid_press();
    bit               found;
    logic [6*WIDTH:0] all_out;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (long_press === 2'b11) begin
        found = 1'b1;
        break;
      end
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL midreset_long: long_press=%b, required 11", long_press);
    end
    rst_n = 1'b0;
    #1;
    all_out = {out, rise, fall, long_press, long_pulse, repeat_pulse, tick};
    tests++;
    if (all_out !== '0) begin
      fails++;
      $display("FAIL midreset_async: outputs=%b, required all zero", all_out);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      tests++;
      if ({tick, fall, repeat_pulse} !== {(i == 4), 4'b0000}) begin
        fails++;
        $display("FAIL midreset_release cycle %0d: tick/fall/repeat=%b, required %b",
                 i, {tick, fall, repeat_pulse}, {(i == 4), 4'b0000});
      end
    end
    for (int i = 0; i < 20; i++) begin
      step();
      tests++;
      if ({fall, repeat_pulse} !== 4'b0000) begin
        fails++;
        $display("FAIL midreset_no_fall cycle %0d: fall/repeat=%b, required 0000", i, {fall, repeat_pulse});
      end
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_press();
    test_long_hold();
    test_simultaneous();
    test_reset_mid_press();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
